// File: rtl/lsu_mem_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store unit memory master. It takes one access at a time from the
// pipeline and turns it into memory read/write cycles on a simple 64-bit,
// big-endian-within-the-word memory port. The byte at mem_addr sits in
// mem_rd_data[63:56] and the byte at mem_addr+7 sits in [7:0].
// Loads read once. Dword stores write once. Narrower stores read the
// surrounding dword, merge the new bytes into its top and write it back.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   When defined, an access whose address is not a multiple of its size
//   completes at once with rsp_err=1, rsp_rdata=0 and no memory cycle.
//   When undefined, rsp_err is tied to 0 and any address is accepted.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   access request
//   req_ready    out  high only when idle
//   req_wr       in   1 = store, 0 = load
//   req_size     in   00 byte, 01 half, 10 word, 11 dword
//   req_signed   in   sign-extend load data
//   req_addr     in   byte address [ADDR_W]
//   req_wdata    in   store data, right-justified [64]
//   rsp_valid    out  one-cycle completion pulse
//   rsp_rdata    out  load result, 0 for stores [64]
//   rsp_err      out  misaligned access flag
//   mem_rd       out  memory read enable
//   mem_wr       out  memory write enable
//   mem_addr     out  memory byte address [ADDR_W]
//   mem_wr_data  out  memory write data [64]
//   mem_rd_data  in   asynchronous memory read data [64]
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wr_data,
    input  logic [63:0]       mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          size_reg;
    logic                signed_reg;
    logic [63:0]         wdata_reg;
    logic [63:0]         rdata_reg;

    logic                accept;
    logic                misaligned;
    logic [63:0]         load_data;
    logic [63:0]         merge_data;

    assign accept = req_valid && (state_reg == IDLE);

`ifdef LSU_ALIGN_CHECK_EN
    logic err_reg;

    // Misaligned when any address bit below the access size is set.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign rsp_err = (state_reg == RESP) && err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Load extraction: the addressed bytes are always the top of the dword.
    always_comb begin
        load_data = '0;
        case (size_reg)
            2'b00:   load_data = {{56{signed_reg & mem_rd_data[63]}}, mem_rd_data[63:56]};
            2'b01:   load_data = {{48{signed_reg & mem_rd_data[63]}}, mem_rd_data[63:48]};
            2'b10:   load_data = {{32{signed_reg & mem_rd_data[63]}}, mem_rd_data[63:32]};
            default: load_data = mem_rd_data;
        endcase
    end

    // Read-modify-write merge: low store bytes replace the top memory bytes.
    always_comb begin
        merge_data = mem_rd_data;
        case (size_reg)
            2'b00:   merge_data = {wdata_reg[7:0],  mem_rd_data[55:0]};
            2'b01:   merge_data = {wdata_reg[15:0], mem_rd_data[47:0]};
            2'b10:   merge_data = {wdata_reg[31:0], mem_rd_data[31:0]};
            default: merge_data = wdata_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (!req_wr) begin
                        state_next = LOAD;
                    end else if (req_size == 2'b11) begin
                        state_next = WRITE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD: begin
                mem_rd     = 1'b1;
                mem_addr   = addr_reg;
                state_next = RESP;
            end
            RMW_RD: begin
                mem_rd     = 1'b1;
                mem_addr   = addr_reg;
                state_next = WRITE;
            end
            WRITE: begin
                mem_wr      = 1'b1;
                mem_addr    = addr_reg;
                mem_wr_data = wdata_reg;
                state_next  = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rdata_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rdata_reg is cleared on accept so stores and errored accesses
    // return zero without a separate path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= req_addr;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                wdata_reg  <= req_wdata;
                rdata_reg  <= '0;
            end
            if (state_reg == LOAD) begin
                rdata_reg <= load_data;
            end
            if (state_reg == RMW_RD) begin
                wdata_reg <= merge_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
//
// Drives lsu_mem_master against a byte-array memory and compares every
// response with a byte-level reference memory: loads concatenate the
// addressed bytes and extend, stores overwrite the addressed bytes.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic          rsp_valid;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wr_data;
    logic [63:0]   mem_rd_data;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // ---------------- memory seen by the DUT ----------------
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [63:0] poke_data = '0;
    int          poke_n = 1;

    always_comb begin
        mem_rd_data = '0;
        for (int k = 0; k < 8; k++)
            mem_rd_data[63-8*k -: 8] = mem[mem_addr + 8'(k)];
    end

    always @(posedge clk) begin
        if (mem_wr)
            for (int k = 0; k < 8; k++)
                mem[mem_addr + 8'(k)] <= mem_wr_data[63-8*k -: 8];
        if (poke_en)
            for (int k = 0; k < poke_n; k++)
                mem[poke_addr + 8'(k)] <= poke_data[8*(poke_n-1-k) +: 8];
    end

    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (mem_rd && mem_wr) overlap_cnt <= overlap_cnt + 1;
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input logic [7:0] addr, input int n, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++)
            v = (v << 8) | 64'(ref_mem[addr + 8'(k)]);
        if (sgn && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [7:0] addr, input int n, input logic [63:0] wd);
        for (int k = 0; k < n; k++)
            ref_mem[addr + 8'(k)] = wd[8*(n-1-k) +: 8];
    endtask

    // Write n bytes (right-justified data) into both memories, DUT idle.
    task automatic poke(input logic [7:0] addr, input logic [63:0] data, input int n);
        ref_store(addr, n, data);
        @(negedge clk);
        poke_addr = addr;
        poke_data = data;
        poke_n    = n;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // One access through the DUT, compared with the reference model.
    task automatic do_req(input string tag, input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [7:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata_o, output int lat_o);
        int n;
        bit mis;
        logic [63:0] exp_rdata;
        int exp_lat, exp_rd, exp_wr;
        int lat, rdc, wrc, waitc;
        logic got_err;
        n = 1 << size;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (int'(addr) % n) != 0;
`else
        mis = 1'b0;
`endif
        exp_rdata = (wr || mis) ? 64'd0 : ref_load(addr, n, sgn);
        exp_lat   = mis ? 1 : ((wr && size != 2'b11) ? 3 : 2);
        exp_rd    = mis ? 0 : ((!wr || size != 2'b11) ? 1 : 0);
        exp_wr    = (!mis && wr) ? 1 : 0;

        @(negedge clk);
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; rdc = 0; wrc = 0;
        rdata_o = '0;
        got_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_rd) rdc++;
            if (mem_wr) wrc++;
            if (rsp_valid) begin
                lat     = c;
                rdata_o = rsp_rdata;
                got_err = rsp_err;
                break;
            end
        end
        lat_o = lat;
        if (wr && !mis) ref_store(addr, n, wdata);

        $display("[TB] %s wr=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 tag, wr, size, sgn, addr, wdata, rdata_o, got_err, lat);
        check({tag, "_lat"},   64'(lat),     64'(exp_lat));
        check({tag, "_rdata"}, rdata_o,      exp_rdata);
        check({tag, "_err"},   64'(got_err), 64'(mis));
        check({tag, "_rdcnt"}, 64'(rdc),     64'(exp_rd));
        check({tag, "_wrcnt"}, 64'(wrc),     64'(exp_wr));
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] rd;
    int          lat;
    int          rsp_at[$];
    int          rst_wr, rst_rsp, diffs;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;

        repeat (3) @(negedge clk);
        check("rst_ready",  64'(req_ready), 64'd1);
        check("rst_rsp",    64'(rsp_valid), 64'd0);
        check("rst_rdata",  rsp_rdata,      64'd0);
        check("rst_err",    64'(rsp_err),   64'd0);
        check("rst_memrd",  64'(mem_rd),    64'd0);
        check("rst_memwr",  64'(mem_wr),    64'd0);
        check("rst_addr",   64'(mem_addr),  64'd0);
        check("rst_wdata",  mem_wr_data,    64'd0);
        rst_n = 1'b1;

        for (int a = 0; a < 256; a += 8)
            poke(8'(a), {$urandom, $urandom}, 8);

        // dword load, two-cycle latency
        poke(8'h10, 64'h2222222222222222, 8);
        do_req("ld_d", 1'b0, 2'b11, 1'b0, 8'h10, 64'd0, rd, lat);
        check("ld_d_const", rd, 64'h2222222222222222);
        check("ld_d_lat2",  64'(lat), 64'd2);

        // signed / unsigned byte
        poke(8'h40, 64'h88, 1);
        do_req("ld_bs", 1'b0, 2'b00, 1'b1, 8'h40, 64'd0, rd, lat);
        check("ld_bs_const", rd, 64'hFFFFFFFFFFFFFF88);
        do_req("ld_bu", 1'b0, 2'b00, 1'b0, 8'h40, 64'd0, rd, lat);
        check("ld_bu_const", rd, 64'h0000000000000088);

        // byte store merged by read-modify-write
        poke(8'h08, 64'h1111111111111111, 8);
        do_req("st_b", 1'b1, 2'b00, 1'b0, 8'h08, 64'hAB, rd, lat);
        check("st_b_lat3", 64'(lat), 64'd3);
        do_req("ld_rmw", 1'b0, 2'b11, 1'b0, 8'h08, 64'd0, rd, lat);
        check("ld_rmw_const", rd, 64'hAB11111111111111);

        // dword store wrapping the address space
        do_req("st_wrap", 1'b1, 2'b11, 1'b0, 8'hFC, 64'h0102030405060708, rd, lat);
`ifndef LSU_ALIGN_CHECK_EN
        check("wrap_hi", 64'({mem[252], mem[253], mem[254], mem[255]}), 64'h01020304);
        check("wrap_lo", 64'({mem[0], mem[1], mem[2], mem[3]}),         64'h05060708);
`endif

        // reset during the read phase of a half store
        poke(8'h20, 64'h5A5A5A5A5A5A5A5A, 8);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 8'h20; req_wdata = 64'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_rmwrd", 64'(mem_rd), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("abort_ready", 64'(req_ready), 64'd1);
        rst_wr = 0; rst_rsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_wr) rst_wr++;
            if (rsp_valid) rst_rsp++;
            if (c == 2) rst_n = 1'b1;
        end
        check("abort_wr",  64'(rst_wr),  64'd0);
        check("abort_rsp", 64'(rst_rsp), 64'd0);
        check("abort_mem", 64'({mem[8'h20], mem[8'h21]}), 64'h5A5A);
        $display("[TB] abort half store addr=20 wr_pulses=%0d rsp=%0d", rst_wr, rst_rsp);

        // three back-to-back loads with req_valid held high
        poke(8'h30, 64'hA1B2C3D4E5F60718, 8);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b11; req_signed = 1'b0;
        req_addr = 8'h30; req_wdata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_at.push_back(i);
                check("b2b_data", rsp_rdata, 64'hA1B2C3D4E5F60718);
                $display("[TB] b2b load rsp at cycle %0d rdata=%h", i, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        check("b2b_count", 64'(rsp_at.size()), 64'd3);
        if (rsp_at.size() == 3) begin
            check("b2b_first", 64'(rsp_at[0]),             64'd2);
            check("b2b_gap1",  64'(rsp_at[1] - rsp_at[0]), 64'd3);
            check("b2b_gap2",  64'(rsp_at[2] - rsp_at[1]), 64'd3);
        end
        repeat (2) @(negedge clk);

        // random traffic
        for (int t = 0; t < 80; t++) begin
            do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   {$urandom, $urandom}, rd, lat);
        end

        @(negedge clk);
        diffs = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) diffs++;
        check("mem_final",   64'(diffs),       64'd0);
        check("rdwr_overlap", 64'(overlap_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
